// File: rtl/serial_pkg.sv
// Shared definitions for the pulse-width-coded serial link (serial_tx / serial_rx).
// Holds the FSM state encoding, the default counter width and the width clamp rule.
package serial_pkg;

    localparam int CNT_W_DEFAULT = 32;
    localparam int WIDTH_MAX     = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MARK  = 2'd1,
        S_SPACE = 2'd2,
        S_FIN   = 2'd3
    } state_e;

    // A programmed pulse width of zero behaves as a single-cycle pulse on both ends of the link.
    function automatic logic [WIDTH_MAX-1:0] clamp_width(input logic [WIDTH_MAX-1:0] w);
        return (w == '0) ? WIDTH_MAX'(1) : w;
    endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Request/line bundle between a serial_tx client (master) and the transmitter (slave).
interface serial_tx_if
    import serial_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int CNT_W  = CNT_W_DEFAULT
);
    logic              start;
    logic [DATA_W-1:0] data;
    logic [7:0]        nbits;
    logic [CNT_W-1:0]  n0;
    logic [CNT_W-1:0]  n1;
    logic              a;
    logic              busy;
    logic              done;

    modport master (output start, data, nbits, n0, n1, input a, busy, done);
    modport slave  (input start, data, nbits, n0, n1, output a, busy, done);
endinterface

// File: rtl/serial_tx_timer.sv
// Loadable down-counter timing the MARK and SPACE phases; last_o flags the final cycle of a phase.
module serial_tx_timer
    import serial_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             last_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: next-state logic defaults to the held value first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/serial_tx.sv
// Pulse-width-coded serial transmitter: sends nbits of data MSB-first as mark pulses plus low gaps.
// Define SERIAL_TX_PARITY_EN to append an even-parity mark after the last data bit.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W     = 256,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input logic        clk,
    input logic        rst,
    serial_tx_if.slave bus
);
    localparam logic [CNT_W-1:0] GAP_W = CNT_W'(GAP_CYCLES);

    state_e            state_q;
    logic              a_q, busy_q, done_q;
    logic [7:0]        idx_q, idx_dec, start_idx;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  n0_q, n1_q, n0_c, n1_c;
    logic              start_bit, next_bit;
    logic              tmr_load, tmr_last;
    logic [CNT_W-1:0]  tmr_val;
`ifdef SERIAL_TX_PARITY_EN
    logic              par_q, par_sent_q;
`endif

    assign n0_c      = CNT_W'(clamp_width(WIDTH_MAX'(bus.n0)));
    assign n1_c      = CNT_W'(clamp_width(WIDTH_MAX'(bus.n1)));
    assign start_idx = bus.nbits - 8'd1;
    assign idx_dec   = idx_q - 8'd1;
    assign start_bit = bus.data[start_idx];
    assign next_bit  = data_q[idx_dec];

    // Timer reload happens on the same edge the FSM enters a new phase.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start && bus.nbits != '0) begin
                    tmr_load = 1'b1;
                    tmr_val  = start_bit ? n1_c : n0_c;
                end
            end
            S_MARK: begin
                if (tmr_last) begin
                    tmr_load = 1'b1;
                    tmr_val  = GAP_W;
                end
            end
            S_SPACE: begin
                if (tmr_last) begin
                    if (idx_q != '0) begin
                        tmr_load = 1'b1;
                        tmr_val  = next_bit ? n1_q : n0_q;
                    end
`ifdef SERIAL_TX_PARITY_EN
                    else if (!par_sent_q) begin
                        tmr_load = 1'b1;
                        tmr_val  = par_q ? n1_q : n0_q;
                    end
`endif
                end
            end
            default: ;
        endcase
    end

    serial_tx_timer #(.CNT_W(CNT_W)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .last_o    (tmr_last)
    );

    // NOTE: shadow registers are always written before they are read, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && bus.start) begin
            data_q <= bus.data;
            n0_q   <= n0_c;
            n1_q   <= n1_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            idx_q      <= '0;
`ifdef SERIAL_TX_PARITY_EN
            par_q      <= 1'b0;
            par_sent_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    a_q    <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.start) begin
                        if (bus.nbits == '0) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q      <= start_idx;
                            state_q    <= S_MARK;
                            a_q        <= 1'b1;
                            busy_q     <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                            par_q      <= start_bit;
                            par_sent_q <= 1'b0;
`endif
                        end
                    end
                end
                S_MARK: begin
                    if (tmr_last) begin
                        state_q <= S_SPACE;
                        a_q     <= 1'b0;
                    end
                end
                S_SPACE: begin
                    if (tmr_last) begin
                        if (idx_q != '0) begin
                            idx_q   <= idx_dec;
                            state_q <= S_MARK;
                            a_q     <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                            par_q   <= par_q ^ next_bit;
`endif
                        end
`ifdef SERIAL_TX_PARITY_EN
                        else if (!par_sent_q) begin
                            par_sent_q <= 1'b1;
                            state_q    <= S_MARK;
                            a_q        <= 1'b1;
                        end
`endif
                        else begin
                            state_q <= S_FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.a    = a_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Pulse-width-coded serial transmitter; the transmitting end of the link decoded by serial_rx.
- Serialises up to 255 bits MSB-first onto a single wire `a`.
- Each bit is a high pulse whose width selects the value (n0 cycles = 0, n1 cycles = 1), followed by a fixed low gap.
- Used in benches and in on-chip loopback to drive serial_rx from programmable word length and pulse widths.

Parameters:
- DATA_W, 256, width of data input bus; bits above nbits-1 are ignored.
- GAP_CYCLES, 1, low cycles after every mark pulse; legal range 1..255.
- CNT_W, 32, width of n0/n1 and internal pulse counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- data  in  DATA_W  word to send; bit nbits-1 goes first.
- nbits  in  8  number of bits to send (0..255).
- n0  in  CNT_W  mark width for a 0 bit, in clocks.
- n1  in  CNT_W  mark width for a 1 bit, in clocks.
- a  out  1  serial line, registered, idle low.
- busy  out  1  high while a word is in flight.
- done  out  1  one-cycle pulse at end of word.

Behaviour:
- Reset (synchronous, active-high: clk edge with rst=1): state=IDLE, a=0, busy=0, done=0, counters=0. rst overrides everything, including mid-word; the line drops low on that edge and the word is abandoned, with no done pulse.
- Latch: on start=1 in IDLE, capture data, nbits, n0, n1 into shadow registers. Inputs may change afterward without effect.
- Width clamp: n0 or n1 equal to 0 is treated as 1. Pulse counter compares at CNT_W bits; no wrap inside a pulse.
- FSM states:
  - IDLE: a=0, busy=0. start with nbits=0 goes directly to FIN. start with nbits>0 loads bit index = nbits-1 and goes to MARK.
  - MARK: a=1, busy=1. Holds for w cycles, where w = n1 if the current bit is 1, else n0, then goes to SPACE.
  - SPACE: a=0, busy=1. Holds for GAP_CYCLES cycles. Then, if bit index = 0, goes to FIN; else decrements the index and goes to MARK.
  - FIN: done=1 for exactly one cycle, busy=0, a=0, then goes to IDLE.
- Latency: start sampled at edge k → a=1 and busy=1 from edge k+1.
- Word length: the word occupies sum(w_i) + nbits*GAP_CYCLES busy cycles, then done follows on the next cycle.
- Back-to-back: start asserted during FIN is ignored. The earliest accepted start is the first IDLE cycle, so words are separated by at least one idle-low cycle after the gap.
- start while busy or in FIN: ignored, no error flag.
- Outputs a, busy, done are all registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro SERIAL_TX_PARITY_EN.
- Defined: after the last data bit's SPACE, one extra mark+gap is sent carrying even parity, i.e. XOR of the nbits transmitted bits. Its width is n1 if the parity is 1, else n0. For nbits=0 no parity bit is sent.
- Undefined: no parity bit; the parity logic is absent.

Decomposition:
- Shared package serial_pkg holds:
  - state encoding localparams (IDLE, MARK, SPACE, FIN);
  - the CNT_W default;
  - the "zero width → 1" clamp rule, as a constant function shared with serial_rx.
- One natural sub-module: serial_tx_timer, a loadable CNT_W down-counter with an expiry flag, used for both MARK and SPACE durations.

Test Plan:
- nbits=16, data=16'h5aaa, n0=2, n1=3, GAP=1: a shows marks 2,3,2,3,3,2,3,2,3,2,3,2,3,2,3,2 separated by single lows. busy is high for 56 cycles; done pulses on cycle 57 after start. Feeding serial_rx with the same settings yields data[15:0]=16'h5aaa.
- nbits=0, start: no mark on a, busy stays 0, done pulses at edge k+1.
- n0=0, n1=0, nbits=2, data=2'b10: both marks are 1 cycle wide; busy lasts 4 cycles.
- Change data/n0/n1 mid-word: the transmitted waveform is unchanged. A start pulse during busy produces no second word.
- rst asserted during the 5th bit's MARK: a=0, busy=0 on the same edge; no done pulse. The next start transmits a full clean word.
- With SERIAL_TX_PARITY_EN, nbits=8, data=8'h07 (three ones): a 9th mark of n1 width is appended; with data=8'h03, the 9th mark has n0 width.
